// File: rtl/ms_pkg.sv
// rtl/ms_pkg.sv - shared types and constants for the minesweeper controller
//
// Purpose: board geometry, cell encoding, controller state and command opcodes.
// Ports:   none (package).
package ms_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [3:0] cell_t;

  localparam cell_t CELL_BOMB = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLACE = 3'd1,
    COUNT = 3'd2,
    PLAY  = 3'd3,
    WON   = 3'd4,
    LOST  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_REVEAL = 2'b00,
    OP_FLAG   = 2'b01
  } cmd_op_t;

endpackage

// File: rtl/neighbour_count.sv
// rtl/neighbour_count.sv - combinational bomb-neighbour counter for one cell
//
// Purpose: counts bombs among the up to 8 neighbours of (row, col), with no
//          wrap across board edges, and reports whether the cell is a bomb.
// Ports:
//   bomb_mask  in  ROWS*COLS  bit r*COLS+c set means a bomb at (r,c)
//   row        in  row of the cell under test
//   col        in  column of the cell under test
//   count      out 4-bit neighbour bomb count (0..8)
//   is_bomb    out cell itself holds a bomb
module neighbour_count
  import ms_pkg::*;
#(
  parameter int ROWS = ms_pkg::ROWS,
  parameter int COLS = ms_pkg::COLS
) (
  input  logic [ROWS*COLS-1:0]     bomb_mask,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(COLS)-1:0]  col,
  output cell_t                    count,
  output logic                     is_bomb
);

  localparam int IDX_W = $clog2(ROWS*COLS);

  always_comb begin
    count   = '0;
    is_bomb = bomb_mask[IDX_W'(int'(row) * COLS + int'(col))];
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        // Bounds are checked on signed coordinates so that edge cells never
        // pick up bits from the opposite side of the board.
        if (!(dr == 0 && dc == 0) &&
            (int'(row) + dr >= 0) && (int'(row) + dr < ROWS) &&
            (int'(col) + dc >= 0) && (int'(col) + dc < COLS)) begin
          if (bomb_mask[IDX_W'((int'(row) + dr) * COLS + int'(col) + dc)]) begin
            count = count + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/minesweeper_ctrl.sv
// rtl/minesweeper_ctrl.sv - game sequencer for the minesweeper board
//
// Purpose: starts the bomb placer, builds the neighbour-count board one cell
//          per cycle, then services reveal/flag commands and declares win/loss.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             one-cycle pulse, begins a new game (IDLE/WON/LOST only)
//   numero_bombas     bomb count, sampled on an accepted start
//   place_start       one-cycle pulse to the bomb placer
//   place_done        placer finished, bomb_map valid this cycle
//   bomb_map          bomb positions, bit r*COLS+c
//   cmd_valid/ready   command handshake, ready only in PLAY
//   cmd_op            00 reveal, 01 flag toggle, others ignored
//   cmd_row, cmd_col  command target cell
//   board             per-cell value: 0..8 neighbour count or 4'hF bomb
//   revealed, flagged per-cell masks
//   busy              high while placing or counting
//   game_won, game_lost  level outputs for the final states
module minesweeper_ctrl
  import ms_pkg::*;
#(
  parameter int ROWS  = ms_pkg::ROWS,
  parameter int COLS  = ms_pkg::COLS,
  parameter int CNT_W = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [5:0]                       numero_bombas,
  output logic                             place_start,
  input  logic                             place_done,
  input  logic [ROWS*COLS-1:0]             bomb_map,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [2:0]                       cmd_row,
  input  logic [2:0]                       cmd_col,
  output logic [ROWS-1:0][COLS-1:0][3:0]   board,
  output logic [ROWS*COLS-1:0]             revealed,
  output logic [ROWS*COLS-1:0]             flagged,
  output logic                             busy,
  output logic                             game_won,
  output logic                             game_lost
);

  localparam int IDX_W = $clog2(ROWS*COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  state_t                 state;
  logic [ROWS*COLS-1:0]   bomb_q;
  logic [5:0]             nb_q;
  logic [CNT_W-1:0]       safe_cnt;
  // The COUNT cell index is kept as separate row/column counters so that no
  // divide is needed to address the neighbour counter.
  logic [RW-1:0]          row_q;
  logic [CW-1:0]          col_q;

  cell_t                  nc_count;
  logic                   nc_is_bomb;

  logic [IDX_W-1:0]       tgt;
  logic [CNT_W-1:0]       safe_next;
  logic [CNT_W-1:0]       win_target;

  assign tgt        = IDX_W'(cmd_row) * IDX_W'(COLS) + IDX_W'(cmd_col);
  assign safe_next  = safe_cnt + 1'b1;
  assign win_target = CNT_W'(ROWS*COLS) - CNT_W'(nb_q);

  neighbour_count #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_neighbour_count (
    .bomb_mask (bomb_q),
    .row       (row_q),
    .col       (col_q),
    .count     (nc_count),
    .is_bomb   (nc_is_bomb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bomb_q      <= '0;
      nb_q        <= '0;
      safe_cnt    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      board       <= '0;
      revealed    <= '0;
      flagged     <= '0;
      place_start <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      game_won    <= 1'b0;
      game_lost   <= 1'b0;
    end else begin
      place_start <= 1'b0;
      case (state)
        IDLE, WON, LOST: begin
          if (start && numero_bombas != 6'd0) begin
            nb_q        <= numero_bombas;
            board       <= '0;
            revealed    <= '0;
            flagged     <= '0;
            safe_cnt    <= '0;
            place_start <= 1'b1;
            busy        <= 1'b1;
            game_won    <= 1'b0;
            game_lost   <= 1'b0;
            state       <= PLACE;
          end
        end

        PLACE: begin
          if (place_done) begin
            bomb_q <= bomb_map;
            row_q  <= '0;
            col_q  <= '0;
            state  <= COUNT;
          end
        end

        COUNT: begin
          board[row_q][col_q] <= nc_is_bomb ? CELL_BOMB : nc_count;
          if (col_q == CW'(COLS-1)) begin
            col_q <= '0;
            if (row_q == RW'(ROWS-1)) begin
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= PLAY;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end

        PLAY: begin
          // cmd_ready is high throughout PLAY, so cmd_valid alone means accept.
          if (cmd_valid) begin
            if (cmd_op == OP_REVEAL) begin
              if (!flagged[tgt] && !revealed[tgt]) begin
                if (bomb_q[tgt]) begin
                  // The hit cell is itself in bomb_q, so OR-ing the map
                  // exposes it together with every other bomb.
                  revealed  <= revealed | bomb_q;
                  cmd_ready <= 1'b0;
                  game_lost <= 1'b1;
                  state     <= LOST;
                end else begin
                  revealed[tgt] <= 1'b1;
                  safe_cnt      <= safe_next;
                  if (safe_next == win_target) begin
                    cmd_ready <= 1'b0;
                    game_won  <= 1'b1;
                    state     <= WON;
                  end
                end
              end
            end else if (cmd_op == OP_FLAG) begin
              if (!revealed[tgt]) begin
                flagged[tgt] <= ~flagged[tgt];
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minesweeper_ctrl.sv
// tb/tb_minesweeper_ctrl.sv - directed self-checking bench for minesweeper_ctrl
module tb_minesweeper_ctrl;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [5:0]             numero_bombas;
  logic                   place_start;
  logic                   place_done;
  logic [63:0]            bomb_map;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [2:0]             cmd_row;
  logic [2:0]             cmd_col;
  logic [7:0][7:0][3:0]   board;
  logic [63:0]            revealed;
  logic [63:0]            flagged;
  logic                   busy;
  logic                   game_won;
  logic                   game_lost;

  int n_err;
  int n_chk;
  int cnt;

  minesweeper_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .numero_bombas (numero_bombas),
    .place_start   (place_start),
    .place_done    (place_done),
    .bomb_map      (bomb_map),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_row       (cmd_row),
    .cmd_col       (cmd_col),
    .board         (board),
    .revealed      (revealed),
    .flagged       (flagged),
    .busy          (busy),
    .game_won      (game_won),
    .game_lost     (game_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input int r, input int c);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = 3'(r);
    cmd_col   = 3'(c);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] nb);
    start         = 1'b1;
    numero_bombas = nb;
    tick();
    start         = 1'b0;
  endtask

  task automatic place(input logic [63:0] map);
    place_done = 1'b1;
    bomb_map   = map;
    tick();
    place_done = 1'b0;
    bomb_map   = '0;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst = 1'b1; start = 1'b0; numero_bombas = '0; place_done = 1'b0;
    bomb_map = '0; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0;
    #3 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    check("rst_board",    64'(board != '0), 64'd0);
    check("rst_revealed", revealed, 64'd0);
    check("rst_flagged",  flagged, 64'd0);
    check("rst_outs", {58'd0, place_start, cmd_ready, busy, game_won, game_lost, 1'b0}, 64'd0);

    // Game 1: ten bombs latched, placer returns bombs at (0,0) and (7,7)
    pulse_start(6'd10);
    check("g1_place_start_pulse", 64'(place_start), 64'd1);
    check("g1_busy_place", 64'(busy), 64'd1);
    tick();
    check("g1_place_start_single", 64'(place_start), 64'd0);
    place(64'h8000_0000_0000_0001);
    cnt = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      cnt++;
      tick();
    end
    check("g1_count_cycles", 64'(cnt), 64'd64);
    check("g1_cmd_ready", 64'(cmd_ready), 64'd1);
    check("b01", 64'(board[0][1]), 64'd1);
    check("b11", 64'(board[1][1]), 64'd1);
    check("b10", 64'(board[1][0]), 64'd1);
    check("b66", 64'(board[6][6]), 64'd1);
    check("b76", 64'(board[7][6]), 64'd1);
    check("b00", 64'(board[0][0]), 64'hF);
    check("b77", 64'(board[7][7]), 64'hF);
    check("b33", 64'(board[3][3]), 64'd0);
    check("b07_nowrap", 64'(board[0][7]), 64'd0);
    check("b70_nowrap", 64'(board[7][0]), 64'd0);
    check("b12", 64'(board[1][2]), 64'd0);

    // Flag interaction on (2,2) = bit 18
    cmd(2'b01, 2, 2);
    check("flag_set", flagged, 64'h0000_0000_0004_0000);
    cmd(2'b00, 2, 2);
    check("reveal_flagged_ignored", revealed, 64'd0);
    cmd(2'b01, 2, 2);
    check("flag_clear", flagged, 64'd0);
    cmd(2'b00, 2, 2);
    check("reveal_unflagged", revealed, 64'h0000_0000_0004_0000);
    cmd(2'b01, 2, 2);
    check("flag_on_revealed", flagged, 64'd0);
    cmd(2'b10, 4, 4);
    check("reserved_op_rev", revealed, 64'h0000_0000_0004_0000);
    check("reserved_op_flag", flagged, 64'd0);

    // start in PLAY is ignored
    pulse_start(6'd3);
    check("play_start_ignored", 64'(place_start), 64'd0);
    check("play_ready_kept", 64'(cmd_ready), 64'd1);

    // Hit the bomb at (0,0)
    cmd(2'b00, 0, 0);
    check("lost", 64'(game_lost), 64'd1);
    check("lost_won_low", 64'(game_won), 64'd0);
    check("lost_revealed", revealed, 64'h8000_0000_0004_0001);
    check("lost_ready", 64'(cmd_ready), 64'd0);
    cmd(2'b00, 3, 3);
    check("lost_hold", revealed, 64'h8000_0000_0004_0001);

    // Game 2: restart from LOST with two bombs, play to a win
    pulse_start(6'd2);
    check("g2_place_start", 64'(place_start), 64'd1);
    check("g2_cleared_rev", revealed, 64'd0);
    check("g2_cleared_board", 64'(board != '0), 64'd0);
    check("g2_lost_cleared", 64'(game_lost), 64'd0);
    tick();
    place(64'h8000_0000_0000_0001);
    for (int i = 0; i < 200 && busy; i++) tick();
    check("g2_ready", 64'(cmd_ready), 64'd1);
    cmd(2'b00, 3, 3);
    cmd(2'b00, 3, 3);
    for (int i = 1; i <= 62; i++) begin
      if (i != 27) begin
        if (i == 62) check("g2_not_won_early", 64'(game_won), 64'd0);
        cmd(2'b00, i / 8, i % 8);
      end
    end
    check("g2_won", 64'(game_won), 64'd1);
    check("g2_won_ready", 64'(cmd_ready), 64'd0);
    check("g2_revealed", revealed, 64'h7FFF_FFFF_FFFF_FFFE);

    // Game 3: zero-bomb start ignored, start in PLACE ignored, reset mid-COUNT
    pulse_start(6'd0);
    check("zero_start_pulse", 64'(place_start), 64'd0);
    check("zero_start_state", 64'(game_won), 64'd1);
    pulse_start(6'd5);
    check("g3_place_start", 64'(place_start), 64'd1);
    check("g3_won_cleared", 64'(game_won), 64'd0);
    tick();
    pulse_start(6'd5);
    check("place_start_again", 64'(place_start), 64'd0);
    check("place_busy", 64'(busy), 64'd1);
    place(64'h0000_0000_0000_0200);
    for (int i = 0; i < 30; i++) tick();
    check("count_busy", 64'(busy), 64'd1);
    check("count_b00", 64'(board[0][0]), 64'd1);
    rst = 1'b0;
    #1;
    check("abort_board", 64'(board != '0), 64'd0);
    check("abort_outs", {58'd0, place_start, cmd_ready, busy, game_won, game_lost, 1'b0}, 64'd0);
    check("abort_masks", revealed | flagged, 64'd0);
    #2 rst = 1'b1;
    tick();
    place(64'h0000_0000_0000_0200);
    tick();
    tick();
    check("late_done_busy", 64'(busy), 64'd0);
    check("late_done_board", 64'(board != '0), 64'd0);
    check("late_done_ready", 64'(cmd_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/minesweeper_ctrl.md
Name: minesweeper_ctrl

Overview:
- Game sequencer for the 8x8 minesweeper board.
- On start, it triggers the bomb placer (colocarBombas) and waits for its bomb map.
- It then builds the 4-bit-per-cell board (neighbour counts plus a bomb marker) one cell per cycle.
- During play it services reveal and flag commands and declares win or loss.

Parameters:
- ROWS, 8, board rows.
- COLS, 8, board columns.
- CNT_W, 7, width of the revealed-safe-cell counter; must hold ROWS*COLS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a new game.
- numero_bombas  in  6  bomb count; sampled on an accepted start.
- place_start  out  1  one-cycle pulse to the bomb placer.
- place_done  in  1  placer finished; bomb_map is valid in the same cycle.
- bomb_map  in  ROWS*COLS  bit r*COLS+c set means a bomb at (r,c).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in PLAY.
- cmd_op  in  2  00 reveal, 01 flag toggle, 10/11 reserved (ignored).
- cmd_row  in  3  target row.
- cmd_col  in  3  target column.
- board  out  [ROWS][COLS][4]  cell values: 0..8 neighbour count, 4'hF bomb.
- revealed  out  ROWS*COLS  revealed mask.
- flagged  out  ROWS*COLS  flag mask.
- busy  out  1  high in PLACE or COUNT.
- game_won  out  1  level, high in WON.
- game_lost  out  1  level, high in LOST.

Behaviour:
- Reset (rst=0, async): state IDLE. board, revealed, flagged, internal bomb register and counters all 0. All outputs 0.
- States: IDLE, PLACE, COUNT, PLAY, WON, LOST.
- IDLE/WON/LOST, start=1 and numero_bombas!=0:
  - Latch numero_bombas.
  - Clear board, revealed, flagged and safe_cnt.
  - Pulse place_start for exactly one cycle; go to PLACE.
- start with numero_bombas==0 is ignored and the state does not change.
- PLACE: wait for place_done. On place_done, register bomb_map, clear cell index idx, go to COUNT. bomb_map is ignored in every other state.
- COUNT: one cell per cycle, idx 0..63 row-major.
  - board[idx] = 4'hF if the cell is a bomb, else the number of bombs among its up to 8 neighbours.
  - Off-board neighbours count as 0: no wrap across rows or columns.
  - After idx=63 is written, go to PLAY. COUNT lasts exactly 64 cycles.
- PLAY: a command is accepted when cmd_valid & cmd_ready. Its effect is visible the cycle after acceptance; at most one command per cycle.
- reveal:
  - Target flagged or already revealed: ignored, no state change.
  - Target is a bomb: set revealed for that cell and every bomb cell; go to LOST.
  - Otherwise: set its revealed bit and increment safe_cnt. If the new safe_cnt == 64 - latched bombs, go to WON in the same update.
- flag toggle: ignored on a revealed cell, else toggles the flagged bit. Flags never affect the win check.
- Reserved ops are accepted and ignored.
- start in PLAY is ignored; only reset or finishing the game leaves PLAY.
- start in PLACE/COUNT is ignored.
- WON/LOST: board and masks hold; cmd_ready=0; an accepted start restarts as from IDLE.
- Reset asserted mid-PLACE/COUNT/PLAY aborts immediately to IDLE. A place_done arriving after reset is ignored because the state is IDLE.
- Arithmetic: neighbour sum is a 4-bit unsigned value (max 8). safe_cnt compares against a CNT_W-bit value 64 - numero_bombas, with no underflow since numero_bombas <= 63.

Decomposition:
- Package ms_pkg holds:
  - ROWS, COLS, CELL_BOMB=4'hF.
  - state_t enum {IDLE, PLACE, COUNT, PLAY, WON, LOST}.
  - cmd_op_t enum {OP_REVEAL, OP_FLAG}.
  - cell_t (logic [3:0]).
- Sub-module neighbour_count: combinational. Inputs are the bomb mask and a row/column; output is a 4-bit count plus an is_bomb flag. The controller instantiates it once and indexes it with idx during COUNT.

Test Plan:
- Reset then start with numero_bombas=10 -> place_start is a single pulse one cycle after start. Stub returns place_done with bombs at (0,0) and (7,7) -> busy high exactly 64 cycles. Required values: board[0][1]=1, board[1][1]=1, board[6][6]=1, board[0][0]=F, board[3][3]=0, corner neighbours without wrap: board[0][7]=0.
- Bombs at (0,0) and (7,7), latched bomb count 2: reveal all 62 safe cells -> game_won rises the cycle after the 62nd accepted reveal. A repeated reveal of (3,3) does not increment the count.
- Reveal bomb (0,0) -> game_lost next cycle; revealed has bits 0 and 63 set; cmd_ready=0.
- Flag (2,2), then reveal (2,2) -> revealed[18] stays 0. Flag (2,2) again, then reveal -> revealed[18]=1. Flag on a revealed cell -> flagged unchanged.
- Reset driven low during COUNT at idx≈30 -> all outputs 0 immediately. A late place_done is ignored and the state stays IDLE.
- start with numero_bombas=0 -> no place_start, state stays IDLE. start during PLACE -> no second place_start pulse.
